// File: rtl/panel_pkg.sv
// Types and width helpers shared across the LED-panel reset and control blocks.
package panel_pkg;

  typedef enum logic [1:0] {
    HOLD,
    WAIT,
    DONE,
    FAULT
  } seq_state_t;

  localparam int unsigned MAX_STAGES = 8;

  // Index/counter width that never collapses to zero bits.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Releases panel subsystems from reset one at a time, each after the previous reports ready,
// and latches a fault when a stage never readies or drops ready after release.
module reset_sequencer
  import panel_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_STAGES-1:0]           stage_ready,
  output logic [NUM_STAGES-1:0]           stage_rst,
  output logic                            all_ready,
  output logic                            fault,
  output logic [width_of(NUM_STAGES)-1:0] fault_stage
);

  localparam int unsigned IDXW = width_of(NUM_STAGES);
  localparam int unsigned CNTW =
    width_of((HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES);

  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYCLES - 1);
  localparam logic [CNTW-1:0] TO_LAST   = CNTW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_STAGES - 1);

  seq_state_t      state;
  logic [CNTW-1:0] count;
  logic [IDXW-1:0] index;

  logic            loss;
  logic [IDXW-1:0] loss_idx;

  // Stages 0..k released, everything above k still held.
  function automatic logic [NUM_STAGES-1:0] released_upto(input logic [IDXW-1:0] k);
    logic [NUM_STAGES-1:0] v;
    v = '0;
    for (int unsigned j = 0; j < NUM_STAGES; j++) begin
      v[j] = (j > 32'(k));
    end
    return v;
  endfunction

  // Lowest already-ready stage that has dropped its ready.
  always_comb begin
    loss     = 1'b0;
    loss_idx = '0;
    for (int unsigned j = 0; j < NUM_STAGES; j++) begin
      if (!loss && !stage_ready[j] &&
          (state == DONE || (state == WAIT && j < 32'(index)))) begin
        loss     = 1'b1;
        loss_idx = IDXW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLD;
      count       <= '0;
      index       <= '0;
      stage_rst   <= '1;
      all_ready   <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= '0;
    end else begin
      if (count != '1) begin
        count <= count + CNTW'(1);
      end
      case (state)
        HOLD: begin
          if (count == HOLD_LAST) begin
            state     <= WAIT;
            count     <= '0;
            index     <= '0;
            stage_rst <= released_upto('0);
          end
        end
        WAIT: begin
          if (loss) begin
            state       <= FAULT;
            stage_rst   <= '1;
            fault       <= 1'b1;
            fault_stage <= loss_idx;
          end else if (stage_ready[index]) begin
            if (index == LAST_IDX) begin
              state     <= DONE;
              all_ready <= 1'b1;
            end else begin
              index     <= index + IDXW'(1);
              count     <= '0;
              stage_rst <= released_upto(index + IDXW'(1));
            end
          end else if (count == TO_LAST) begin
            state       <= FAULT;
            stage_rst   <= '1;
            fault       <= 1'b1;
            fault_stage <= index;
          end
        end
        DONE: begin
          if (loss) begin
            state       <= FAULT;
            stage_rst   <= '1;
            all_ready   <= 1'b0;
            fault       <= 1'b1;
            fault_stage <= loss_idx;
          end
        end
        default: begin
          stage_rst <= '1;
          all_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues each expected output change with its edge number,
// a negedge monitor pops and compares whenever the DUT outputs change.
module tb_reset_sequencer;

  localparam int unsigned NS   = 4;
  localparam int unsigned HOLD = 16;
  localparam int unsigned TO   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] stage_ready;
  logic [NS-1:0] stage_rst;
  logic          all_ready;
  logic          fault;
  logic [1:0]    fault_stage;

  int unsigned edge_n = 0;
  int unsigned asserts = 0;
  int unsigned fails = 0;

  typedef struct {
    int unsigned at;
    logic [3:0]  sr;
    logic        ar;
    logic        f;
    logic [1:0]  fs;
  } ev_t;

  ev_t q[$];

  reset_sequencer #(
    .NUM_STAGES    (NS),
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stage_ready(stage_ready),
    .stage_rst  (stage_rst),
    .all_ready  (all_ready),
    .fault      (fault),
    .fault_stage(fault_stage)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: every output change must match the next queued event, on the queued edge.
  logic [7:0] prev_out = 'x;
  always @(negedge clk) begin
    logic [7:0] cur;
    ev_t e;
    cur = {stage_rst, all_ready, fault, fault_stage};
    if (cur !== prev_out) begin
      asserts++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change edge %0d: got sr=%b ar=%b f=%b fs=%0d, required no change",
                 edge_n, stage_rst, all_ready, fault, fault_stage);
      end else begin
        e = q.pop_front();
        if (edge_n != e.at || cur !== {e.sr, e.ar, e.f, e.fs}) begin
          fails++;
          $display("FAIL event: got edge %0d sr=%b ar=%b f=%b fs=%0d, required edge %0d sr=%b ar=%b f=%b fs=%0d",
                   edge_n, stage_rst, all_ready, fault, fault_stage,
                   e.at, e.sr, e.ar, e.f, e.fs);
        end
      end
      prev_out = cur;
    end
  end

  task automatic expect_ev(input int unsigned at, input logic [3:0] sr,
                           input logic ar, input logic f, input logic [1:0] fs);
    ev_t e;
    e.at = at; e.sr = sr; e.ar = ar; e.f = f; e.fs = fs;
    q.push_back(e);
  endtask

  task automatic step_to(input int unsigned e);
    while (edge_n < e) @(negedge clk);
  endtask

  // Assert rst for n edges from now; returns the last edge that sampled rst=1.
  task automatic do_reset(input int unsigned n, output int unsigned base);
    rst = 1'b1;
    stage_ready = '0;
    expect_ev(edge_n + 1, 4'b1111, 1'b0, 1'b0, 2'd0);
    step_to(edge_n + n);
    rst = 1'b0;
    base = edge_n;
  endtask

  // Full sequence, each ready raised 3 cycles after its stage is released.
  task automatic happy_chain(input int unsigned base, output int unsigned r);
    logic [3:0] ones;
    ones = 4'b1111;
    r = base + HOLD;
    expect_ev(r, 4'b1110, 1'b0, 1'b0, 2'd0);
    for (int unsigned k = 0; k < NS; k++) begin
      step_to(r + 2);
      stage_ready[k] = 1'b1;
      r = r + 3;
      expect_ev(r, ones << (k + 2), (k == NS - 1), 1'b0, 2'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int unsigned r;
    rst = 1'b1;
    stage_ready = '0;

    // Run 1: happy path, then a one-cycle drop of stage 0 ready in DONE.
    do_reset(5, base);
    happy_chain(base, r);
    step_to(r + 2);
    stage_ready[0] = 1'b0;
    expect_ev(r + 3, 4'b1111, 1'b0, 1'b1, 2'd0);
    step_to(r + 3);
    stage_ready[0] = 1'b1;
    step_to(r + 5);

    // Run 2: stage 1 ready on the timeout edge, stage 2 never ready.
    do_reset(1, base);
    r = base + HOLD;
    expect_ev(r, 4'b1110, 1'b0, 1'b0, 2'd0);
    step_to(r + 2);
    stage_ready[0] = 1'b1;
    r = r + 3;
    expect_ev(r, 4'b1100, 1'b0, 1'b0, 2'd0);
    step_to(r + TO - 1);
    stage_ready[1] = 1'b1;
    r = r + TO;
    expect_ev(r, 4'b1000, 1'b0, 1'b0, 2'd0);
    expect_ev(r + TO, 4'b1111, 1'b0, 1'b1, 2'd2);
    step_to(r + TO + 2);

    // Run 3: one-cycle rst pulse while waiting on stage 2.
    do_reset(1, base);
    r = base + HOLD;
    expect_ev(r, 4'b1110, 1'b0, 1'b0, 2'd0);
    step_to(r + 2);
    stage_ready[0] = 1'b1;
    r = r + 3;
    expect_ev(r, 4'b1100, 1'b0, 1'b0, 2'd0);
    step_to(r + 2);
    stage_ready[1] = 1'b1;
    r = r + 3;
    expect_ev(r, 4'b1000, 1'b0, 1'b0, 2'd0);
    step_to(r + 1);
    do_reset(1, base);

    // Run 4: full resequence after the pulse.
    happy_chain(base, r);
    step_to(r + 6);

    asserts++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d outstanding, required 0 (next edge %0d)",
               q.size(), q[0].at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the board-level conditioned reset and releases the LED-panel subsystems from reset one at a time, in a fixed order. Each stage's reset is deasserted only after the previous stage has reported ready. It sits directly downstream of the reset conditioner and drives the per-block resets of the panel pipeline (clock/PLL monitor, frame buffer, scan driver, UART command path). It detects stages that never come ready, or that drop ready after release, and holds the system in a reported fault state.

## Interface
- NUM_STAGES, 4, number of sequenced downstream stages (1..8)
- HOLD_CYCLES, 16, cycles all stage resets stay asserted after `rst` falls (>=1)
- TIMEOUT_CYCLES, 1024, max cycles to wait for a released stage's ready (>=1)
- clk  input  1  system clock; the only clock
- rst  input  1  reset, synchronous, active-high; driven by the conditioned board reset
- stage_ready  input  NUM_STAGES  per-stage ready, synchronous to `clk`; bit k belongs to stage k
- stage_rst  output  NUM_STAGES  per-stage reset, active-high, registered
- all_ready  output  1  high while every stage is released and ready, registered
- fault  output  1  sticky fault flag, registered
- fault_stage  output  max(1,$clog2(NUM_STAGES))  index of the failing stage, valid while `fault`=1

## Operation
- States:
  - HOLD: all `stage_rst`=1; counter runs.
  - WAIT(k): stages 0..k released; waiting for ready of stage k; k held in a stage index register.
  - DONE: all released; `all_ready`=1.
  - FAULT: all `stage_rst`=1; `fault`=1; terminal until `rst`.
- Reset values, at the first edge with `rst`=1:
  - state HOLD, counter 0, index 0.
  - `stage_rst` all ones, `all_ready`=0, `fault`=0, `fault_stage`=0.
- `rst` high mid-operation, in any state including FAULT: returns to reset values on the next edge. Full resequence follows.
- HOLD -> WAIT(0): when the counter reaches HOLD_CYCLES-1. On that edge `stage_rst[0]` clears and the counter clears.
- WAIT(k):
  - `stage_ready[k]` sampled 1: if k<NUM_STAGES-1, go to WAIT(k+1), clear `stage_rst[k+1]` and the counter on the same edge; else go to DONE and set `all_ready`.
  - Counter reaches TIMEOUT_CYCLES-1 with `stage_ready[k]`=0: go to FAULT with `fault_stage`=k.
- Ready loss: in WAIT(k) or DONE, any already-ready stage j (j<k in WAIT, any j in DONE) sampled 0 -> FAULT, `fault_stage`=lowest such j.
- Priority on one edge, highest first: `rst`, then ready loss, then ready of stage k, then timeout. Ready arriving on the timeout edge counts as success.
- `stage_ready` of unreleased stages is ignored.
- FAULT: `stage_rst` all ones, `all_ready`=0; `fault_stage` stays frozen.
- Counter width: $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)). Counter saturates and never wraps.

## Timing
- E0 = first edge sampling `rst`=0.
- `stage_rst[0]` falls after edge E0+HOLD_CYCLES-1 and is visible for cycle E0+HOLD_CYCLES.
- Per-stage handoff latency: 1 edge. `stage_ready[k]` sampled on edge E -> `stage_rst[k+1]`=0 after E.
- `all_ready` rises on the edge sampling `stage_ready[NUM_STAGES-1]`=1. It falls on the edge that detects ready loss.
- Timeout: stage k released at edge R with no ready -> FAULT after edge R+TIMEOUT_CYCLES.
- All outputs come directly from flops. There is no combinational path from inputs to outputs.

## Structure
- Shared package `panel_pkg`: state enum (HOLD, WAIT, DONE, FAULT) and a `clog2`-based width helper constant.
- Single module; counter and index register are inline, no sub-module.
- The stage_rst vector is formed from the index register: bit j = 1 iff j > index, or state is HOLD or FAULT.

## Test plan
Bench overrides: NUM_STAGES=4, HOLD_CYCLES=16, TIMEOUT_CYCLES=32.
- Happy path: `rst` 1 for 5 cycles, then each ready asserted 3 cycles after its release. Required: `stage_rst` goes 1111 -> 1110 after 16 cycles -> 1100 -> 1000 -> 0000; `all_ready`=1 after the last ready; `fault`=0.
- Timeout: stage 2 never readies. Required: FAULT exactly 32 edges after `stage_rst[2]` falls; `fault_stage`=2; `stage_rst`=1111; `all_ready`=0.
- Boundary: `stage_ready[1]` rises on the 32nd edge after release. Required: no fault; stage 2 released on the same edge.
- Ready loss: drop `stage_ready[0]` for 1 cycle while in DONE. Required: FAULT; `fault_stage`=0; `all_ready` falls on that edge.
- Reset mid-sequence: pulse `rst` for 1 cycle during WAIT(2). Required: outputs return to reset values next edge; full resequence with 16-cycle hold; prior fault cleared.
